dense_layer_argmax_fsm: RTL and testbench
=========================================

# dense_layer_argmax_fsm

Parametrised fully-connected layer engine with a built-in argmax classifier. It is the next generation of the fixed 16→10 output-layer FSM. Input count, neuron count, data/weight widths, fixed-point shifts, memory base addresses and memory read latency are all parameters. It adds a start/busy handshake, a per-neuron ReLU result stream, and optional saturating accumulation. It sits after a hidden layer, reads biases and weights from the shared byte-wide parameter ROM, and emits every neuron output plus the winning class index.

## Interface
- N_IN, 16, number of layer inputs (≥1)
- N_OUT, 10, number of neurons (≥2)
- IN_W, 26, signed input width (Q14.12)
- W_W, 8, signed weight/bias byte width (weights Q3.5, biases Q4.4)
- WEIGHT_SHIFT, 7, left shift applied to weight before multiply
- BIAS_SHIFT, 20, left shift applied to bias when loaded into accumulator
- ACC_W, 46, signed accumulator/output width; must be ≥ IN_W+W_W+WEIGHT_SHIFT+clog2(N_IN+1)
- ADDR_WIDTH, 14, parameter memory address width
- BIAS_BASE, 13344, address of bias for neuron 0 (bias n at BIAS_BASE+n)
- WEIGHT_BASE, 13354, address of weight (n,j) at WEIGHT_BASE+n*N_IN+j
- MEM_LAT, 2, wait cycles between address issue and data sampling (≥0)
- CLS_W, $clog2(N_OUT), class index width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only in IDLE
- busy  out  1  high from the accept edge until done pulses
- in_data  in  N_IN*IN_W  packed signed inputs, element j at [j*IN_W +: IN_W]; sampled on the accept edge only
- mem_addr  out  ADDR_WIDTH  registered parameter memory address
- mem_data  in  W_W  signed byte from parameter memory
- out_valid  out  1  one-cycle pulse per completed neuron
- out_idx  out  CLS_W  neuron index for out_valid
- out_data  out  ACC_W  ReLU'd accumulator for out_idx
- final_class  out  CLS_W  argmax index, held until next accept
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ADDR, WAIT, MAC, EMIT, FINISH.
- IDLE + start: latch in_data, set n=0, f=0 (f=0 is the bias, f=1..N_IN are weights j=f-1), clear max (max_val=0, max_idx=0), busy=1, go to ADDR. start while busy is ignored.
- ADDR: mem_addr ← BIAS_BASE+n when f=0, otherwise WEIGHT_BASE+n*N_IN+(f-1). Wait counter is cleared. Go to WAIT, or directly to MAC if MEM_LAT=0.
- WAIT: stay for MEM_LAT cycles, then go to MAC.
- MAC, f=0: acc ← sign-extended mem_data <<< BIAS_SHIFT.
- MAC, f>0: acc ← acc + (in[f-1] × (mem_data <<< WEIGHT_SHIFT)). The product is computed full-width signed, then sign-extended to ACC_W.
- MAC then goes to ADDR with f+1, or to EMIT if f=N_IN.
- EMIT: out_valid=1, out_idx=n, out_data=(acc<0)?0:acc.
  - If relu(acc) > max_val (strict): max_val ← relu(acc), max_idx ← n.
  - Ties keep the lowest index. If all neurons are ≤0, the class is 0.
  - Then n+1 with f=0 goes to ADDR; if n=N_OUT-1, go to FINISH.
- FINISH: final_class ← max_idx, done=1, busy=0, go to IDLE.
- Reset (any time, including mid-run): state=IDLE. All outputs go to 0: busy, done, out_valid, out_idx, out_data, final_class, mem_addr. acc, max_val and max_idx are also cleared.

## Timing
- One memory fetch takes MEM_LAT+2 cycles: ADDR, then MEM_LAT×WAIT, then MAC.
- mem_data is sampled at the MAC edge, which is MEM_LAT+1 edges after the edge that drove mem_addr.
- One neuron takes X = (N_IN+1)(MEM_LAT+2)+1 cycles.
- Start accepted at edge 0 → out_valid for neuron n is high after edge (n+1)·X. done is high after edge 1+N_OUT·X.
  - Defaults: X=69, done after edge 691.
- busy falls on the same edge that done rises. A new start is accepted at the earliest on the edge after done.
- mem_addr holds its last value while the block is in IDLE.

## Configuration
- ACC_SAT_EN defined:
  - Every accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The sum is computed at ACC_W+1 bits, then clamped.
  - The bias load cannot overflow when the parameter rule holds.
- ACC_SAT_EN undefined: accumulation wraps modulo 2^ACC_W, with no extra logic.

## Test plan
- Defaults, all inputs 0, biases {-3,5,2,…} (others 0) → out_data n=1 is 5<<20, class=1, done after edge 691.
- N_IN=2, N_OUT=3, MEM_LAT=0:
  - Inputs 4096 and -4096, zero biases, weights row1 {32,0} and rows 0,2 zero.
  - Response: out_data[1]=4096·(32<<7)=16777216, class=1, done after edge 1+3·7=22.
- Ties and negatives:
  - Biases {-1,-1,…}, zero weights → all out_data 0, class 0.
  - Biases {0,7,7,0,…} → class 1.
- Reset asserted mid-run (edge 100):
  - Next edge: busy=0, mem_addr=0, out_valid=0.
  - A start after reset reproduces a clean run with identical results.
- start held high for the whole run → exactly one run. A second run begins on the edge after done, and done pulses exactly once per run.
- ACC_W=24, input 2^25-1, weights 127:
  - With ACC_SAT_EN: out_data clamps to 2^23-1.
  - Without ACC_SAT_EN: the value is the wrapped result.

Source files
------------

// File: rtl/dense_layer_argmax_fsm_if.sv
// Start/busy handshake, parameter-memory port and result stream of dense_layer_argmax_fsm.
interface dense_layer_argmax_fsm_if #(
  parameter int N_IN       = 16,
  parameter int IN_W       = 26,
  parameter int W_W        = 8,
  parameter int ACC_W      = 46,
  parameter int ADDR_WIDTH = 14,
  parameter int CLS_W      = 4
);
  logic                   start;
  logic                   busy;
  logic [N_IN*IN_W-1:0]   in_data;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [W_W-1:0]         mem_data;
  logic                   out_valid;
  logic [CLS_W-1:0]       out_idx;
  logic [ACC_W-1:0]       out_data;
  logic [CLS_W-1:0]       final_class;
  logic                   done;

  modport master (
    output start, in_data, mem_data,
    input  busy, mem_addr, out_valid, out_idx, out_data, final_class, done
  );
  modport slave (
    input  start, in_data, mem_data,
    output busy, mem_addr, out_valid, out_idx, out_data, final_class, done
  );
endinterface

// File: rtl/dense_layer_argmax_fsm.sv
// Fully-connected layer with ReLU result stream and argmax class output.
// Optional ACC_SAT_EN: saturating accumulation instead of modulo-2^ACC_W wrap.
module dense_layer_argmax_fsm #(
  parameter int N_IN         = 16,
  parameter int N_OUT        = 10,
  parameter int IN_W         = 26,
  parameter int W_W          = 8,
  parameter int WEIGHT_SHIFT = 7,
  parameter int BIAS_SHIFT   = 20,
  parameter int ACC_W        = 46,
  parameter int ADDR_WIDTH   = 14,
  parameter int BIAS_BASE    = 13344,
  parameter int WEIGHT_BASE  = 13354,
  parameter int MEM_LAT      = 2,
  parameter int CLS_W        = $clog2(N_OUT)
) (
  input  logic clk,
  input  logic rst,
  dense_layer_argmax_fsm_if.slave io
);
  localparam int FW   = $clog2(N_IN + 1);
  localparam int WC_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam int WSW  = W_W + WEIGHT_SHIFT;
  localparam int PW   = IN_W + WSW;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_MAC, S_EMIT, S_FINISH} state_t;

  state_t                      state_q;
  logic [CLS_W-1:0]            n_q, max_idx_q, out_idx_q, final_class_q;
  logic [FW-1:0]               f_q;
  logic [WC_W-1:0]             wait_q;
  logic [N_IN-1:0][IN_W-1:0]   in_q;
  logic signed [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]            max_q, out_data_q;
  logic [ADDR_WIDTH-1:0]       mem_addr_q;
  logic                        busy_q, done_q, out_valid_q;

  logic signed [IN_W-1:0]      in_sel;
  logic signed [WSW-1:0]       w_sh;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_W-1:0]     bias_ext, acc_d;
  logic [ACC_W-1:0]            relu;
  logic [ADDR_WIDTH-1:0]       addr_d;

  always_comb begin
    in_sel = '0;
    for (int j = 0; j < N_IN; j++)
      if (int'(f_q) == j + 1) in_sel = in_q[j];
  end

  assign w_sh     = WSW'($signed(io.mem_data)) <<< WEIGHT_SHIFT;
  assign prod     = PW'(in_sel) * PW'(w_sh);
  assign bias_ext = ACC_W'($signed(io.mem_data)) <<< BIAS_SHIFT;
  assign relu     = acc_q[ACC_W-1] ? '0 : acc_q;
  assign addr_d   = (f_q == '0) ? ADDR_WIDTH'(BIAS_BASE + int'(n_q))
                                : ADDR_WIDTH'(WEIGHT_BASE + int'(n_q) * N_IN + int'(f_q) - 1);

`ifdef ACC_SAT_EN
  // One guard bit above the wider of accumulator and product, so the clamp decision is exact.
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  logic signed [SW-1:0] sum;
  always_comb begin
    sum = SW'(acc_q) + SW'(prod);
    if (sum[SW-1:ACC_W-1] == '0 || sum[SW-1:ACC_W-1] == '1)
      acc_d = sum[ACC_W-1:0];
    else if (sum[SW-1])
      acc_d = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_d = {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  always_comb begin
    acc_d = acc_q + ACC_W'(prod);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      f_q           <= '0;
      wait_q        <= '0;
      acc_q         <= '0;
      max_q         <= '0;
      max_idx_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_data_q    <= '0;
      final_class_q <= '0;
      mem_addr_q    <= '0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (io.start) begin
          in_q      <= io.in_data;
          n_q       <= '0;
          f_q       <= '0;
          max_q     <= '0;
          max_idx_q <= '0;
          busy_q    <= 1'b1;
          state_q   <= S_ADDR;
        end
        S_ADDR: begin
          mem_addr_q <= addr_d;
          wait_q     <= '0;
          state_q    <= (MEM_LAT == 0) ? S_MAC : S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WC_W'(MEM_LAT - 1)) state_q <= S_MAC;
          else wait_q <= wait_q + WC_W'(1);
        end
        S_MAC: begin
          acc_q <= (f_q == '0) ? bias_ext : acc_d;
          if (int'(f_q) == N_IN) state_q <= S_EMIT;
          else begin
            f_q     <= f_q + FW'(1);
            state_q <= S_ADDR;
          end
        end
        S_EMIT: begin
          out_valid_q <= 1'b1;
          out_idx_q   <= n_q;
          out_data_q  <= relu;
          // strict compare keeps the lowest index on ties
          if (relu > max_q) begin
            max_q     <= relu;
            max_idx_q <= n_q;
          end
          f_q <= '0;
          if (int'(n_q) == N_OUT - 1) state_q <= S_FINISH;
          else begin
            n_q     <= n_q + CLS_W'(1);
            state_q <= S_ADDR;
          end
        end
        S_FINISH: begin
          final_class_q <= max_idx_q;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.mem_addr    = mem_addr_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_idx     = out_idx_q;
  assign io.out_data    = out_data_q;
  assign io.final_class = final_class_q;
endmodule

// File: tb/tb_dense_layer_argmax_fsm.sv
// Scoreboard bench: three configurations (default, small 2x3 zero-latency, narrow 24-bit accumulator).
module tb_dense_layer_argmax_fsm;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   dca = 0, dcb = 0, dcc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; int idx; logic [63:0] data; } oexp_t;
  typedef struct { int at; int cls; } dexp_t;
  oexp_t qoa[$], qob[$], qoc[$];
  dexp_t qda[$], qdb[$], qdc[$];
  logic [63:0] ev [10];

  dense_layer_argmax_fsm_if #(.N_IN(16), .IN_W(26), .W_W(8), .ACC_W(46), .ADDR_WIDTH(14), .CLS_W(4)) ia();
  dense_layer_argmax_fsm_if #(.N_IN(2),  .IN_W(26), .W_W(8), .ACC_W(46), .ADDR_WIDTH(14), .CLS_W(2)) ib();
  dense_layer_argmax_fsm_if #(.N_IN(1),  .IN_W(26), .W_W(8), .ACC_W(24), .ADDR_WIDTH(14), .CLS_W(1)) ic();

  dense_layer_argmax_fsm ua (.clk(clk), .rst(rst), .io(ia));
  dense_layer_argmax_fsm #(.N_IN(2), .N_OUT(3), .MEM_LAT(0), .BIAS_BASE(0), .WEIGHT_BASE(3))
    ub (.clk(clk), .rst(rst), .io(ib));
  dense_layer_argmax_fsm #(.N_IN(1), .N_OUT(2), .ACC_W(24), .MEM_LAT(0), .BIAS_BASE(0), .WEIGHT_BASE(2))
    uc (.clk(clk), .rst(rst), .io(ic));

  // Parameter ROMs; the default config gets a true two-stage read pipeline.
  logic [7:0] romA [16384];
  logic [7:0] romB [16];
  logic [7:0] romC [16];
  logic [7:0] pa0, pa1;
  always @(posedge clk) begin
    pa0 <= romA[ia.mem_addr];
    pa1 <= pa0;
  end
  assign ia.mem_data = pa1;
  assign ib.mem_data = romB[ib.mem_addr[3:0]];
  assign ic.mem_data = romC[ic.mem_addr[3:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic spur(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin : mon_a
    oexp_t e; dexp_t d;
    if (ia.out_valid === 1'b1) begin
      if (qoa.size() == 0) spur("A unexpected out_valid");
      else begin
        e = qoa.pop_front();
        chk("A out_idx", 64'(ia.out_idx), 64'(e.idx));
        chk("A out_data", 64'(ia.out_data), e.data);
        chk("A emit edge", 64'(cyc), 64'(e.at));
      end
    end
    if (ia.done === 1'b1) begin
      dca++;
      if (qda.size() == 0) spur("A unexpected done");
      else begin
        d = qda.pop_front();
        chk("A final_class", 64'(ia.final_class), 64'(d.cls));
        chk("A done edge", 64'(cyc), 64'(d.at));
        chk("A busy at done", 64'(ia.busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    oexp_t e; dexp_t d;
    if (ib.out_valid === 1'b1) begin
      if (qob.size() == 0) spur("B unexpected out_valid");
      else begin
        e = qob.pop_front();
        chk("B out_idx", 64'(ib.out_idx), 64'(e.idx));
        chk("B out_data", 64'(ib.out_data), e.data);
        chk("B emit edge", 64'(cyc), 64'(e.at));
      end
    end
    if (ib.done === 1'b1) begin
      dcb++;
      if (qdb.size() == 0) spur("B unexpected done");
      else begin
        d = qdb.pop_front();
        chk("B final_class", 64'(ib.final_class), 64'(d.cls));
        chk("B done edge", 64'(cyc), 64'(d.at));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    oexp_t e; dexp_t d;
    if (ic.out_valid === 1'b1) begin
      if (qoc.size() == 0) spur("C unexpected out_valid");
      else begin
        e = qoc.pop_front();
        chk("C out_idx", 64'(ic.out_idx), 64'(e.idx));
        chk("C out_data", 64'(ic.out_data), e.data);
        chk("C emit edge", 64'(cyc), 64'(e.at));
      end
    end
    if (ic.done === 1'b1) begin
      dcc++;
      if (qdc.size() == 0) spur("C unexpected done");
      else begin
        d = qdc.pop_front();
        chk("C final_class", 64'(ic.final_class), 64'(d.cls));
        chk("C done edge", 64'(cyc), 64'(d.at));
      end
    end
  end

  function automatic int dc(input int w);
    return (w == 0) ? dca : (w == 1) ? dcb : dcc;
  endfunction

  // Push expectations for neurons 0..upto-1; the done entry only for a complete run.
  task automatic expect_run(input int w, input int acc, input int nout, input int x,
                            input int cls, input int upto);
    oexp_t o; dexp_t d;
    for (int n = 0; n < upto; n++) begin
      o.at = acc + (n + 1) * x; o.idx = n; o.data = ev[n];
      case (w)
        0: qoa.push_back(o);
        1: qob.push_back(o);
        default: qoc.push_back(o);
      endcase
    end
    if (upto == nout) begin
      d.at = acc + 1 + nout * x; d.cls = cls;
      case (w)
        0: qda.push_back(d);
        1: qdb.push_back(d);
        default: qdc.push_back(d);
      endcase
    end
  endtask

  task automatic kick(input int w, input logic [415:0] din, input bit hold, output int acc);
    @(negedge clk);
    case (w)
      0: begin ia.in_data = din; ia.start = 1'b1; end
      1: begin ib.in_data = din[51:0]; ib.start = 1'b1; end
      default: begin ic.in_data = din[25:0]; ic.start = 1'b1; end
    endcase
    @(posedge clk); #1;
    acc = cyc;
    case (w)
      0: begin chk("A busy after accept", 64'(ia.busy), 64'd1);
               if (!hold) begin ia.start = 1'b0; ia.in_data = '0; end end
      1: begin chk("B busy after accept", 64'(ib.busy), 64'd1);
               ib.start = 1'b0; ib.in_data = '0; end
      default: begin chk("C busy after accept", 64'(ic.busy), 64'd1);
               ic.start = 1'b0; ic.in_data = '0; end
    endcase
  endtask

  task automatic wait_done(input int w);
    int c0;
    c0 = dc(w);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (dc(w) != c0) break;
    end
    if (dc(w) == c0) spur("done timeout");
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 10; i++) ev[i] = '0;
  endtask

  task automatic clear_a(input logic [7:0] wfill);
    for (int i = 13344; i < 13354; i++) romA[i] = 8'h00;
    for (int i = 13354; i < 13354 + 160; i++) romA[i] = wfill;
  endtask

  logic [415:0] din, d5;
  int acc;

  initial begin
    rst = 1'b1;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    ia.in_data = '0; ib.in_data = '0; ic.in_data = '0;
    for (int i = 0; i < 16384; i++) romA[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin romB[i] = 8'h00; romC[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(ia.busy), 64'd0);
    chk("reset done", 64'(ia.done), 64'd0);
    chk("reset out_valid", 64'(ia.out_valid), 64'd0);
    chk("reset out_idx", 64'(ia.out_idx), 64'd0);
    chk("reset out_data", 64'(ia.out_data), 64'd0);
    chk("reset final_class", 64'(ia.final_class), 64'd0);
    chk("reset mem_addr", 64'(ia.mem_addr), 64'd0);
    rst = 1'b0;

    // Zero inputs, biases {-3,5,2,0..}; weights nonzero but irrelevant.
    clear_a(8'h7F);
    romA[13344] = 8'hFD; romA[13345] = 8'h05; romA[13346] = 8'h02;
    clear_ev(); ev[1] = 64'd5242880; ev[2] = 64'd2097152;
    kick(0, '0, 1'b0, acc); expect_run(0, acc, 10, 69, 1, 10); wait_done(0);

    // All biases -1, zero weights, nonzero inputs: everything ReLUs to 0, class 0.
    clear_a(8'h00);
    for (int i = 13344; i < 13354; i++) romA[i] = 8'hFF;
    din = '0;
    for (int j = 0; j < 16; j++) din[j*26 +: 26] = 26'd4096;
    clear_ev();
    kick(0, din, 1'b0, acc); expect_run(0, acc, 10, 69, 0, 10); wait_done(0);

    // Tie between neurons 1 and 2 resolves to the lower index.
    clear_a(8'h00);
    romA[13345] = 8'h07; romA[13346] = 8'h07;
    clear_ev(); ev[1] = 64'd7340032; ev[2] = 64'd7340032;
    kick(0, din, 1'b0, acc); expect_run(0, acc, 10, 69, 1, 10); wait_done(0);

    // Weighted sums: n4 = 1.0*1.0, n5 = bias 1.0 - 2.0 (clipped), n6 = 1+1 wins.
    clear_a(8'h00);
    romA[13349] = 8'h10;
    romA[13354 + 4*16 + 3] = 8'd32;
    romA[13354 + 5*16 + 0] = 8'd64;
    romA[13354 + 6*16 + 3] = 8'd32;
    romA[13354 + 6*16 + 0] = 8'hE0;
    d5 = '0;
    d5[0*26 +: 26] = 26'h3FFF000;
    d5[1*26 +: 26] = 26'd12345;
    d5[3*26 +: 26] = 26'd4096;
    clear_ev(); ev[4] = 64'd16777216; ev[6] = 64'd33554432;
    kick(0, d5, 1'b0, acc); expect_run(0, acc, 10, 69, 6, 10); wait_done(0);

    // Reset on edge acc+100: only neuron 0 is emitted before it.
    kick(0, d5, 1'b0, acc); expect_run(0, acc, 10, 69, 6, 1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 64'(ia.busy), 64'd0);
    chk("midrst mem_addr", 64'(ia.mem_addr), 64'd0);
    chk("midrst out_valid", 64'(ia.out_valid), 64'd0);
    chk("midrst final_class", 64'(ia.final_class), 64'd0);
    rst = 1'b0;
    kick(0, d5, 1'b0, acc); expect_run(0, acc, 10, 69, 6, 10); wait_done(0);

    // start held high: second run accepted on the edge after done, one done per run.
    clear_ev(); ev[4] = 64'd16777216; ev[6] = 64'd33554432;
    kick(0, d5, 1'b1, acc);
    expect_run(0, acc, 10, 69, 6, 10);
    expect_run(0, acc + 692, 10, 69, 6, 10);
    wait_done(0);
    @(posedge clk); #1;
    chk("A restart busy", 64'(ia.busy), 64'd1);
    ia.start = 1'b0;
    wait_done(0);
    repeat (20) @(negedge clk);

    // Small config: inputs {1.0,-1.0}, row1 weights {1.0,0}.
    romB[5] = 8'd32;
    din = '0; din[0 +: 26] = 26'd4096; din[26 +: 26] = 26'h3FFF000;
    clear_ev(); ev[1] = 64'd16777216;
    kick(1, din, 1'b0, acc); expect_run(1, acc, 3, 7, 1, 3); wait_done(1);

    // 24-bit accumulator, input 2^25-1, weights 127 and -128.
    romC[2] = 8'h7F; romC[3] = 8'h80;
    din = '0; din[0 +: 26] = 26'h1FFFFFF;
    clear_ev();
`ifdef ACC_SAT_EN
    ev[0] = 64'd8388607;
    kick(2, din, 1'b0, acc); expect_run(2, acc, 2, 5, 0, 2); wait_done(2);
`else
    ev[1] = 64'd16384;
    kick(2, din, 1'b0, acc); expect_run(2, acc, 2, 5, 1, 2); wait_done(2);
`endif
    repeat (5) @(negedge clk);

    chk("A queue drained", 64'(qoa.size() + qda.size()), 64'd0);
    chk("B queue drained", 64'(qob.size() + qdb.size()), 64'd0);
    chk("C queue drained", 64'(qoc.size() + qdc.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
